// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - bit-serial ripple-borrow subtractor, LSB first, Start/Busy/Done handshake
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] DIFF,
    output logic             B_out
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_a, reg_b, res_q, res_next;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q, bit_d, borrow_d;
    logic             accept, last_bit;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        bit_d    = reg_a[0] ^ reg_b[0] ^ borrow_q;
        borrow_d = (~reg_a[0] & reg_b[0]) | (~(reg_a[0] ^ reg_b[0]) & borrow_q);
        res_next = {bit_d, res_q[WIDTH-1:1]};
        case (state_q)
            IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    last_bit = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Partial results live only in res_q; DIFF is loaded once per completion.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            reg_a    <= '0;
            reg_b    <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            Done     <= 1'b0;
            DIFF     <= '0;
            B_out    <= 1'b0;
        end else begin
            Done <= last_bit;
            if (accept) begin
                reg_a    <= A;
                reg_b    <= B;
                borrow_q <= B_in;
                cnt_q    <= '0;
            end else if (state_q == RUN) begin
                reg_a    <= reg_a >> 1;
                reg_b    <= reg_b >> 1;
                res_q    <= res_next;
                borrow_q <= borrow_d;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (last_bit) begin
                DIFF  <= res_next;
                B_out <= borrow_d;
            end
        end
    end

    assign Busy = (state_q == RUN);

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - self-checking bench for serial_subtractor_8bit
module tb_serial_subtractor_8bit;
    localparam int WIDTH = 8;

    logic             Clock = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             B_in = 1'b0;
    logic             Busy, Done, B_out;
    logic [WIDTH-1:0] DIFF;

    int total = 0;
    int bad = 0;

    serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B), .B_in(B_in),
        .Busy(Busy), .Done(Done), .DIFF(DIFF), .B_out(B_out)
    );

    always #5 Clock = ~Clock;

    // Reference: plain unsigned arithmetic; bit WIDTH is the borrow-out.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        ref_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    endfunction

    // Call with inputs settled off-edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        Start = 1'b1; A = a; B = b; B_in = bi;
        @(posedge Clock); #1;
        Start = 1'b0; A = WIDTH'($urandom); B = WIDTH'($urandom); B_in = 1'($urandom);
    endtask

    // Waits for Done, scrambling operand inputs each cycle; optionally pulses Start
    // on cycle poke_cyc with the given operands. Reports latency in edges and Busy cycles.
    task automatic wait_done(input int poke_cyc, input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                             output int lat, output int busy_cnt, output logic ok, output logic diff_moved);
        logic [WIDTH-1:0] diff0;
        diff0 = DIFF;
        lat = 0; busy_cnt = Busy ? 1 : 0; ok = 1'b0; diff_moved = 1'b0;
        for (int i = 0; i < 3 * WIDTH + 8; i++) begin
            if (poke_cyc != 0 && i + 1 == poke_cyc) begin
                Start = 1'b1; A = pa; B = pb; B_in = 1'b0;
            end else begin
                Start = 1'b0; A = WIDTH'($urandom); B = WIDTH'($urandom); B_in = 1'($urandom);
            end
            @(posedge Clock); #1;
            lat++;
            Start = 1'b0;
            if (Done) begin
                ok = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            if (DIFF !== diff0) diff_moved = 1'b1;
        end
    endtask

    task automatic check_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                            input logic [WIDTH-1:0] exp_d, input logic exp_bo);
        int lat, bc;
        logic ok, moved;
        start_op(a, b, bi);
        wait_done(0, '0, '0, lat, bc, ok, moved);
        total++;
        if (!ok) begin bad++; $display("FAIL %s done_timeout got no Done expected Done", name); end
        total++;
        if ({B_out, DIFF} !== {exp_bo, exp_d}) begin
            bad++; $display("FAIL %s result got %0b/%h expected %0b/%h", name, B_out, DIFF, exp_bo, exp_d);
        end
        total++;
        if (lat !== WIDTH || bc !== WIDTH) begin
            bad++; $display("FAIL %s latency got lat=%0d busy=%0d expected %0d/%0d", name, lat, bc, WIDTH, WIDTH);
        end
        total++;
        if (moved !== 1'b0) begin bad++; $display("FAIL %s diff_hold got moved=1 expected 0", name); end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({Busy, Done, DIFF, B_out} !== '0) begin
            bad++; $display("FAIL reset_state got busy=%0b done=%0b diff=%h bout=%0b expected all 0", Busy, Done, DIFF, B_out);
        end
        @(negedge Clock); Reset_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_directed();
        logic [WIDTH:0] e;
        check_op("t1_35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        @(posedge Clock); #1;
        total++;
        if (Done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got %0b expected 0", Done); end
        check_op("t2_12_35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1);
        check_op("t2_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        check_op("t3_00_00_1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        check_op("t3_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        e = ref_sub(8'hFF, 8'h00, 1'b0);
        check_op("t3_ff_00_0", 8'hFF, 8'h00, 1'b0, e[WIDTH-1:0], e[WIDTH]);
    endtask

    task automatic test_busy_collision();
        int lat, bc;
        logic ok, moved;
        start_op(8'h50, 8'h20, 1'b0);
        wait_done(3, 8'h01, 8'h02, lat, bc, ok, moved);
        total++;
        if (!ok || {B_out, DIFF} !== {1'b0, 8'h30}) begin
            bad++; $display("FAIL busy_collision got ok=%0b %0b/%h expected 1 0/30", ok, B_out, DIFF);
        end
        total++;
        if (lat !== WIDTH) begin bad++; $display("FAIL busy_collision_lat got %0d expected %0d", lat, WIDTH); end
        @(posedge Clock); #1;
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL busy_collision_idle got busy=%0b expected 0", Busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic ok, moved;
        check_op("b2b_first", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        start_op(8'h10, 8'h11, 1'b0);
        wait_done(0, '0, '0, lat, bc, ok, moved);
        total++;
        if (!ok || lat !== WIDTH || {B_out, DIFF} !== {1'b1, 8'hFF}) begin
            bad++; $display("FAIL back_to_back got ok=%0b lat=%0d %0b/%h expected 1 %0d 1/ff", ok, lat, B_out, DIFF, WIDTH);
        end
        total++;
        if (moved !== 1'b0) begin bad++; $display("FAIL back_to_back_hold got moved=1 expected DIFF held 23"); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_op(8'h35, 8'h12, 1'b0);
        repeat (3) @(posedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({Busy, Done, DIFF, B_out} !== '0) begin
            bad++; $display("FAIL reset_mid got busy=%0b done=%0b diff=%h bout=%0b expected all 0", Busy, Done, DIFF, B_out);
        end
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        seen = 1'b0;
        repeat (2 * WIDTH) begin
            @(posedge Clock); #1;
            if (Done || Busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_done got activity=1 expected 0"); end
        check_op("reset_mid_fresh", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic bi;
        logic [WIDTH:0] e;
        for (int n = 0; n < 40; n++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); bi = 1'($urandom);
            e = ref_sub(a, b, bi);
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            #1;
            check_op("random", a, b, bi, e[WIDTH-1:0], e[WIDTH]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
